// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the uart_tx round-robin arbiter.
//   arb_state_e   : arbiter FSM states (2-bit encoding)
//   BUSY_TIMEOUT  : cycles to wait for tx_ready to drop after tx_start
//   BYTE_W        : width of one requester byte
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BUSY = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_GAP_WAIT  = 2'd3
  } arb_state_e;

  localparam int unsigned BUSY_TIMEOUT = 4;
  localparam int unsigned TO_W         = $clog2(BUSY_TIMEOUT);
  localparam int unsigned BYTE_W       = 8;

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker.
//   req     : request vector
//   ptr     : index of the last winner; search starts at ptr+1 and wraps
//   valid_c : at least one request is set
//   grant_c : index of the winning requester (0 when none)
module uart_tx_arbiter_rr_picker #(
  parameter  int unsigned NREQ  = 4,
  localparam int unsigned IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid_c,
  output logic [IDX_W-1:0] grant_c
);

  logic [IDX_W-1:0] idx;

  // First set request after ptr, visiting ptr+1 .. ptr+NREQ modulo NREQ
  always_comb begin
    valid_c = 1'b0;
    grant_c = '0;
    idx     = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = IDX_W'((32'(ptr) + k) % NREQ);
      if (!valid_c && req[idx]) begin
        valid_c = 1'b1;
        grant_c = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among NREQ byte requesters with round-robin arbitration,
// sequences the tx_start/tx_ready handshake and inserts an optional idle gap.
//   clk, rstn : clock, async active-low reset
//   req, data : per-requester level request and byte (requester i owns data[8i+7:8i])
//   ack       : one-cycle pulse, byte of the granted requester accepted
//   tx_data   : byte to uart_tx, held until the next grant
//   tx_start  : one-cycle start pulse to uart_tx
//   tx_ready  : uart_tx idle flag
//   grant_id  : index of the last granted requester
//   busy      : high from tx_start until the frame (and gap) completes
//   tx_err    : one-cycle pulse when uart_tx never dropped tx_ready after start
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter  int unsigned NREQ  = 4,
  parameter  int unsigned GAP   = 0,
  localparam int unsigned IDX_W = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NREQ-1:0]          req,
  input  logic [BYTE_W*NREQ-1:0]   data,
  output logic [NREQ-1:0]          ack,
  output logic [BYTE_W-1:0]        tx_data,
  output logic                     tx_start,
  input  logic                     tx_ready,
  output logic [IDX_W-1:0]         grant_id,
  output logic                     busy,
  output logic                     tx_err
);

  localparam int unsigned GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;
  logic [IDX_W-1:0]  grant_id_q, grant_id_d;
  logic              busy_q, busy_d;
  logic              tx_err_q, tx_err_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;

  logic              pick_valid_c;
  logic [IDX_W-1:0]  pick_c;
  logic [BYTE_W-1:0] data_byte [NREQ];

  // Unflatten the byte bus so the winner can be selected by index
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_bytes
    assign data_byte[gi] = data[BYTE_W*gi +: BYTE_W];
  end

  uart_tx_arbiter_rr_picker #(.NREQ(NREQ)) u_picker (
    .req     (req),
    .ptr     (ptr_q),
    .valid_c (pick_valid_c),
    .grant_c (pick_c)
  );

  // State and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      ptr_q      <= IDX_W'(NREQ - 1);
      ack_q      <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
      tx_err_q   <= 1'b0;
      to_cnt_q   <= '0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      ack_q      <= ack_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      grant_id_q <= grant_id_d;
      busy_q     <= busy_d;
      tx_err_q   <= tx_err_d;
      to_cnt_q   <= to_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  // Next-state and output logic; pulses default low, data/ids hold
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    ack_d      = '0;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    grant_id_d = grant_id_q;
    busy_d     = busy_q;
    tx_err_d   = 1'b0;
    to_cnt_d   = to_cnt_q;
    gap_cnt_d  = gap_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_valid_c && tx_ready) begin
          tx_data_d  = data_byte[pick_c];
          ack_d      = NREQ'(1) << pick_c;
          tx_start_d = 1'b1;
          grant_id_d = pick_c;
          ptr_d      = pick_c;
          busy_d     = 1'b1;
          to_cnt_d   = '0;
          state_d    = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        // Transmitter must acknowledge the start by dropping tx_ready
        if (!tx_ready) begin
          state_d = ST_WAIT_DONE;
        end else if (to_cnt_q == TO_W'(BUSY_TIMEOUT - 1)) begin
          tx_err_d = 1'b1;
          busy_d   = 1'b0;
          state_d  = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (tx_ready) begin
          if (GAP > 0) begin
            gap_cnt_d = GAP_W'(GAP);
            state_d   = ST_GAP_WAIT;
          end else begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end
      ST_GAP_WAIT: begin
        if (gap_cnt_q == '0) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ack      = ack_q;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;
  assign tx_err   = tx_err_q;

endmodule
